// File: rtl/if_id_stage.sv
// IF/ID pipeline register with RV32I field/immediate decode and valid/ready handshake.
// Optional feature macro: IF_ID_SKID_EN selects a two-entry skid buffer with a registered in_ready.
module if_id_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_we
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_we;
    } entry_t;

    entry_t      dec_c;
    logic [2:0]  fmt_c;
    logic        rs1_v, rs2_v, rd_v, f7_v;
    logic [31:0] imm32_c;

    // Input-side decode; fields that the format does not use are forced to zero.
    always_comb begin
        case (in_instr[6:0])
            7'b0110011:                                     fmt_c = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_c = FMT_I;
            7'b0100011:                                     fmt_c = FMT_S;
            7'b1100011:                                     fmt_c = FMT_B;
            7'b0110111, 7'b0010111:                         fmt_c = FMT_U;
            7'b1101111:                                     fmt_c = FMT_J;
            default:                                        fmt_c = FMT_ILL;
        endcase
        rs1_v = (fmt_c == FMT_R) || (fmt_c == FMT_I) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
        rs2_v = (fmt_c == FMT_R) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
        rd_v  = (fmt_c == FMT_R) || (fmt_c == FMT_I) || (fmt_c == FMT_U) || (fmt_c == FMT_J);
        f7_v  = (fmt_c == FMT_R);
        case (fmt_c)
            FMT_I:   imm32_c = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm32_c = {in_instr[31:12], 12'b0};
            FMT_J:   imm32_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default: imm32_c = 32'd0;
        endcase
        dec_c.pc       = in_pc;
        dec_c.opcode   = in_instr[6:0];
        dec_c.rd       = rd_v  ? in_instr[11:7]  : 5'd0;
        dec_c.rs1      = rs1_v ? in_instr[19:15] : 5'd0;
        dec_c.rs2      = rs2_v ? in_instr[24:20] : 5'd0;
        dec_c.funct3   = rs1_v ? in_instr[14:12] : 3'd0;
        dec_c.funct7   = f7_v  ? in_instr[31:25] : 7'd0;
        dec_c.imm      = XLEN'($signed(imm32_c));
        dec_c.fmt      = fmt_c;
        dec_c.rs1_used = rs1_v;
        dec_c.rs2_used = rs2_v;
        dec_c.rd_we    = rd_v && (in_instr[11:7] != 5'd0);
    end

    entry_t main_q, main_d;
    logic   accept, xfer;

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

`ifdef IF_ID_SKID_EN
    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_MAIN = 2'd1, ST_FULL = 2'd2} state_t;

    state_t state_q, state_d;
    entry_t skid_q, skid_d;
    logic   ready_q;

    // ready_q already reflects the upcoming state, so in_ready never sees out_ready.
    assign in_ready = ready_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = dec_c;
                    state_d = ST_MAIN;
                end
            end
            ST_MAIN: begin
                if (accept && xfer) begin
                    main_d = dec_c;
                end else if (accept) begin
                    skid_d  = dec_c;
                    state_d = ST_FULL;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    main_d  = skid_q;
                    state_d = ST_MAIN;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        out_valid = (state_q != ST_EMPTY);
    end
`else
    logic vld_q, vld_d;

    assign in_ready = !rst && (!vld_q || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            main_q <= '0;
        end else begin
            vld_q  <= vld_d;
            main_q <= main_d;
        end
    end

    always_comb begin
        vld_d  = vld_q;
        main_d = main_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (accept) begin
            vld_d  = 1'b1;
            main_d = dec_c;
        end else if (xfer) begin
            vld_d = 1'b0;
        end
    end

    assign out_valid = vld_q;
`endif

    assign out_pc       = main_q.pc;
    assign out_opcode   = main_q.opcode;
    assign out_rd       = main_q.rd;
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;
    assign out_funct3   = main_q.funct3;
    assign out_funct7   = main_q.funct7;
    assign out_imm      = main_q.imm;
    assign out_fmt      = main_q.fmt;
    assign out_rs1_used = main_q.rs1_used;
    assign out_rs2_used = main_q.rs2_used;
    assign out_rd_we    = main_q.rd_we;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage against an in-order queue model with a spec-level decoder.
// Honours IF_ID_SKID_EN for the expected in_ready / capacity behaviour.
module tb_if_id_stage;
    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [6:0]      out_opcode, out_funct7;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [2:0]      out_funct3, out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_rs1_used, out_rs2_used, out_rd_we;

    if_id_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
        .out_rd_we(out_rd_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd, rs1, rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            rs1_used, rs2_used, rd_we;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exit_pc_q[$];
    int          exit_cyc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          zero_chk = 0;
    logic [63:0] ones_x;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Decoder written from the format tables: fields as integers, immediate as a signed value.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
        exp_t        d;
        longint      v;
        int          w;
        logic [63:0] tmp;
        case (ins[6:0])
            7'h33:                      d.fmt = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73: d.fmt = 3'd1;
            7'h23:                      d.fmt = 3'd2;
            7'h63:                      d.fmt = 3'd3;
            7'h37, 7'h17:               d.fmt = 3'd4;
            7'h6F:                      d.fmt = 3'd5;
            default:                    d.fmt = 3'd7;
        endcase
        d.pc       = pc;
        d.opcode   = ins[6:0];
        d.rs1_used = (d.fmt <= 3'd3);
        d.rs2_used = (d.fmt == 3'd0) || (d.fmt == 3'd2) || (d.fmt == 3'd3);
        d.rs1      = d.rs1_used ? ins[19:15] : 5'd0;
        d.rs2      = d.rs2_used ? ins[24:20] : 5'd0;
        d.funct3   = d.rs1_used ? ins[14:12] : 3'd0;
        d.funct7   = (d.fmt == 3'd0) ? ins[31:25] : 7'd0;
        d.rd       = ((d.fmt <= 3'd1) || (d.fmt == 3'd4) || (d.fmt == 3'd5)) ? ins[11:7] : 5'd0;
        d.rd_we    = (d.rd != 5'd0);
        v = 0;
        w = 1;
        case (d.fmt)
            3'd1: begin v = longint'(ins[31:20]); w = 12; end
            3'd2: begin v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); w = 12; end
            3'd3: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                w = 13;
            end
            3'd4: begin v = longint'(ins[31:12]) * 4096; w = 32; end
            3'd5: begin
                v = longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                w = 21;
            end
            default: begin v = 0; w = 1; end
        endcase
        if (((v >> (w - 1)) & 1) != 0) v = v - (longint'(1) << w);
        tmp   = v;
        d.imm = tmp[XLEN-1:0];
        return d;
    endfunction

    task automatic compare_front(input exp_t e);
        check("pc", out_pc, e.pc);
        check("opcode", out_opcode, e.opcode);
        check("rd", out_rd, e.rd);
        check("rs1", out_rs1, e.rs1);
        check("rs2", out_rs2, e.rs2);
        check("funct3", out_funct3, e.funct3);
        check("funct7", out_funct7, e.funct7);
        check("imm", out_imm, e.imm);
        check("fmt", out_fmt, e.fmt);
        check("rs1_used", out_rs1_used, e.rs1_used);
        check("rs2_used", out_rs2_used, e.rs2_used);
        check("rd_we", out_rd_we, e.rd_we);
    endtask

    // One clock: check at negedge against the model, then advance the model at posedge.
    task automatic step(output bit acc);
        bit exp_rdy, xf;
        @(negedge clk);
`ifdef IF_ID_SKID_EN
        exp_rdy = !rst && (exp_q.size() < 2);
`else
        exp_rdy = !rst && ((exp_q.size() == 0) || out_ready);
`endif
        check("out_valid", out_valid, exp_q.size() != 0);
        check("in_ready", in_ready, exp_rdy);
        if (exp_q.size() != 0) compare_front(exp_q[0]);
        if (zero_chk) begin
            check("rst_pc", out_pc, 0);
            check("rst_imm", out_imm, 0);
            check("rst_flags", {out_rs1_used, out_rs2_used, out_rd_we, out_fmt, out_opcode}, 0);
        end
        acc = in_valid && exp_rdy;
        xf  = (exp_q.size() != 0) && out_ready;
        if (xf && !rst && !flush) begin
            exit_pc_q.push_back(out_pc);
            exit_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            zero_chk = 1;
        end else begin
            zero_chk = 0;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (xf) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(ref_decode(in_instr, in_pc));
            end
        end
        #1;
    endtask

    task automatic do_reset();
        bit a;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        step(a);
        rst = 1'b0;
    endtask

    task automatic send_one(input logic [31:0] ins, input logic [PC_W-1:0] pc);
        bit a;
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        step(a);
        in_valid = 1'b0;
        check("dir_accept", a, 1);
    endtask

    // Offer PCs 0x0,0x4,0x8 for n cycles; returns how many were accepted.
    task automatic stream(input int n, inout int idx);
        bit a;
        for (int c = 0; c < n; c++) begin
            in_valid = (idx < 3);
            in_pc    = PC_W'(idx * 4);
            in_instr = 32'h0000_0013 | (32'(idx + 1) << 7);
            step(a);
            if (a) idx++;
        end
        in_valid = 1'b0;
    endtask

    logic [6:0] opcs [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                              7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B};

    initial begin
        bit          acc;
        int          idx;
        logic [31:0] r;
        logic [PC_W-1:0] pc_ctr;
        ones_x = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = '0;
        @(posedge clk); #1;
        do_reset();

        // Directed decode vectors.
        out_ready = 1'b1;
        send_one(32'hFFF0_0093, 32'h100);
        check("addi_fmt", out_fmt, 1);
        check("addi_rd", out_rd, 1);
        check("addi_rs1", out_rs1, 0);
        check("addi_imm", out_imm, ones_x);
        check("addi_rd_we", out_rd_we, 1);
        check("addi_rs2_used", out_rs2_used, 0);
        check("addi_funct7", out_funct7, 0);
        send_one(32'h0020_A423, 32'h104);
        check("sw_fmt", out_fmt, 2);
        check("sw_rs1", out_rs1, 1);
        check("sw_rs2", out_rs2, 2);
        check("sw_imm", out_imm, 8);
        check("sw_rd", {out_rd, out_rd_we}, 0);
        send_one(32'hFE20_8EE3, 32'h108);
        check("beq_fmt", out_fmt, 3);
        check("beq_imm", out_imm, ones_x & ~64'h3);
        send_one(32'h0000_007F, 32'h10C);
        check("ill_fmt", out_fmt, 7);
        check("ill_imm", out_imm, 0);
        check("ill_fields", {out_rd, out_rs1, out_rs2, out_funct7}, 0);
        check("ill_flags", {out_rs1_used, out_rs2_used, out_rd_we}, 0);
        step(acc);

        // Backpressure then release: exit order and consecutive cycles.
        do_reset();
        idx = 0;
        out_ready = 1'b0;
        stream(3, idx);
`ifdef IF_ID_SKID_EN
        check("bp_accepts", idx, 2);
`else
        check("bp_accepts", idx, 1);
`endif
        exit_pc_q.delete();
        exit_cyc_q.delete();
        out_ready = 1'b1;
        stream(4, idx);
        check("bp_exit_cnt", exit_pc_q.size(), 3);
        if (exit_pc_q.size() == 3) begin
            for (int i = 0; i < 3; i++) check("bp_exit_pc", exit_pc_q[i], 64'(i * 4));
            check("bp_consecutive", exit_cyc_q[2] - exit_cyc_q[0], 2);
        end

        // Flush while stalled and full, with an input offered.
        do_reset();
        idx = 0;
        out_ready = 1'b0;
        stream(2, idx);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0050_0293; in_pc = 32'h200;
        step(acc);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_ov", out_valid, 0);
        out_ready = 1'b1;
        step(acc);
        check("flush_dropped", out_valid, 0);

        // Reset in the middle of a stall.
        idx = 0;
        out_ready = 1'b0;
        stream(2, idx);
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        check("rst_ov", out_valid, 0);
        check("rst_data", {out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_funct7}, 0);
        step(acc);

        // Randomized traffic with backpressure, flushes and occasional reset.
        pc_ctr = 32'h1000;
        acc = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc) begin
                r = $urandom();
                r[6:0] = opcs[$urandom_range(0, 11)];
                in_valid = ($urandom_range(0, 3) != 0);
                in_instr = r;
                in_pc    = pc_ctr;
                pc_ctr   = pc_ctr + 4;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            step(acc);
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
